// File: rtl/rs_issue_sel.sv
// ----------------------------------------------------------------------------
// rs_issue_sel
//
// Issue selector on the consumer side of the reservation-station buffers.
// Every cycle it looks at the per-entry ready vectors for the three execution
// ports and registers at most one one-hot select per port:
//   port 0 = AGU, port 1 = ALU 1, port 2 = ALU 2.
// Each port searches round-robin from its own rotation pointer. Entries already
// picked by a lower-numbered port in the same cycle are skipped. Entries
// selected in the previous cycle are masked on every port. Per-port saturating
// counters record how many issues each port has made.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset (clears selects, pointers, counters)
//   rst_thread   synchronous thread flush (clears selects and pointers only)
//   stall        freeze issue for this edge (selects go to zero)
//   portReady0-2 per-entry ready vectors for ports 0..2
//   outRsSelect0-2 registered one-hot selects for ports 0..2
//   issueValid   bit p is high when port p has a select this cycle
//   issueCnt0-2  saturating issue counters for ports 0..2
// ----------------------------------------------------------------------------
module rs_issue_sel #(
    parameter int ENTRIES = 8,
    parameter int CNTW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rst_thread,
    input  logic                stall,
    input  logic [ENTRIES-1:0]  portReady0,
    input  logic [ENTRIES-1:0]  portReady1,
    input  logic [ENTRIES-1:0]  portReady2,
    output logic [ENTRIES-1:0]  outRsSelect0,
    output logic [ENTRIES-1:0]  outRsSelect1,
    output logic [ENTRIES-1:0]  outRsSelect2,
    output logic [2:0]          issueValid,
    output logic [CNTW-1:0]     issueCnt0,
    output logic [CNTW-1:0]     issueCnt1,
    output logic [CNTW-1:0]     issueCnt2
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] readyV [3];
    logic [ENTRIES-1:0] selQ   [3];
    logic [ENTRIES-1:0] selD   [3];
    logic [PW-1:0]      ptrQ   [3];
    logic [PW-1:0]      ptrD   [3];
    logic [CNTW-1:0]    cntQ   [3];
    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] avail;

    // First set bit of vec, searching upward from ptr and wrapping past the
    // top entry back to entry 0. Returns a one-hot vector, or zero when
    // nothing is eligible.
    function automatic logic [ENTRIES-1:0] pickOne(
        input logic [ENTRIES-1:0] vec,
        input logic [PW-1:0]      ptr
    );
        logic [ENTRIES-1:0] res;
        logic               found;
        logic [PW:0]        pos;
        logic [PW-1:0]      idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            pos = {1'b0, ptr} + (PW+1)'(i);
            if (pos >= (PW+1)'(ENTRIES)) begin
                pos = pos - (PW+1)'(ENTRIES);
            end
            idx = pos[PW-1:0];
            if (!found && vec[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    // Pointer value that follows a one-hot grant: the granted index plus one,
    // wrapping to zero after the top entry. Holds the old pointer when there
    // is no grant.
    function automatic logic [PW-1:0] nextPtr(
        input logic [ENTRIES-1:0] oneHot,
        input logic [PW-1:0]      ptr
    );
        logic [PW-1:0] res;
        res = ptr;
        for (int i = 0; i < ENTRIES; i++) begin
            if (oneHot[i]) begin
                res = (i == ENTRIES - 1) ? '0 : PW'(i + 1);
            end
        end
        return res;
    endfunction

    assign readyV[0] = portReady0;
    assign readyV[1] = portReady1;
    assign readyV[2] = portReady2;

    // Pick logic. Entries granted last cycle are masked on all ports, and
    // every pick is removed from the pool before the next port searches, so
    // the three picks can never overlap.
    always_comb begin
        busy  = selQ[0] | selQ[1] | selQ[2];
        avail = ~busy;
        for (int p = 0; p < 3; p++) begin
            selD[p] = pickOne(readyV[p] & avail, ptrQ[p]);
            ptrD[p] = nextPtr(selD[p], ptrQ[p]);
            avail   = avail & ~selD[p];
        end
    end

    // State update. Full reset beats thread flush, which beats stall. A
    // thread flush keeps the performance counters. Stall only blanks the
    // selects and leaves pointers and counters untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < 3; p++) begin
                selQ[p] <= '0;
                ptrQ[p] <= '0;
                cntQ[p] <= '0;
            end
        end else if (rst_thread) begin
            for (int p = 0; p < 3; p++) begin
                selQ[p] <= '0;
                ptrQ[p] <= '0;
            end
        end else if (stall) begin
            for (int p = 0; p < 3; p++) begin
                selQ[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                selQ[p] <= selD[p];
                ptrQ[p] <= ptrD[p];
                if ((|selD[p]) && (cntQ[p] != '1)) begin
                    cntQ[p] <= cntQ[p] + CNTW'(1);
                end
            end
        end
    end

    assign outRsSelect0 = selQ[0];
    assign outRsSelect1 = selQ[1];
    assign outRsSelect2 = selQ[2];
    assign issueValid   = {|selQ[2], |selQ[1], |selQ[0]};
    assign issueCnt0    = cntQ[0];
    assign issueCnt1    = cntQ[1];
    assign issueCnt2    = cntQ[2];

endmodule

// File: tb/tb_rs_issue_sel.sv
// ----------------------------------------------------------------------------
// tb_rs_issue_sel
//
// Testbench for rs_issue_sel. The driver applies one set of inputs per cycle.
// It advances a reference model of the issue rules and queues the outputs
// expected after the next rising edge. A separate monitor pops one expectation
// per cycle and compares it against the DUT. The counter width is shortened so
// that counter saturation is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_rs_issue_sel;

    localparam int E    = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [E-1:0]  s0;
        logic [E-1:0]  s1;
        logic [E-1:0]  s2;
        logic [2:0]    v;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        logic [CW-1:0] c2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rst_thread = 1'b0;
    logic          stall = 1'b0;
    logic [E-1:0]  portReady0 = '0;
    logic [E-1:0]  portReady1 = '0;
    logic [E-1:0]  portReady2 = '0;
    logic [E-1:0]  outRsSelect0;
    logic [E-1:0]  outRsSelect1;
    logic [E-1:0]  outRsSelect2;
    logic [2:0]    issueValid;
    logic [CW-1:0] issueCnt0;
    logic [CW-1:0] issueCnt1;
    logic [CW-1:0] issueCnt2;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    // Reference model state: granted entry index per port (-1 = none),
    // rotation pointer and issue count per port.
    int mSel[3] = '{-1, -1, -1};
    int mPtr[3] = '{0, 0, 0};
    int mCnt[3] = '{0, 0, 0};

    rs_issue_sel #(.ENTRIES(E), .CNTW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rst_thread   (rst_thread),
        .stall        (stall),
        .portReady0   (portReady0),
        .portReady1   (portReady1),
        .portReady2   (portReady2),
        .outRsSelect0 (outRsSelect0),
        .outRsSelect1 (outRsSelect1),
        .outRsSelect2 (outRsSelect2),
        .issueValid   (issueValid),
        .issueCnt0    (issueCnt0),
        .issueCnt1    (issueCnt1),
        .issueCnt2    (issueCnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [E-1:0] toVec(input int idx);
        logic [E-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the rules of the selector.
    task automatic modelStep(input logic [E-1:0] r0, input logic [E-1:0] r1,
                             input logic [E-1:0] r2, input logic st,
                             input logic thr, input logic rn);
        logic [E-1:0] rdy[3];
        bit           used[E];
        int           newSel[3];
        exp_t         e;
        rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
        for (int p = 0; p < 3; p++) newSel[p] = -1;
        if (!rn) begin
            for (int p = 0; p < 3; p++) begin mPtr[p] = 0; mCnt[p] = 0; end
        end else if (thr) begin
            for (int p = 0; p < 3; p++) mPtr[p] = 0;
        end else if (!st) begin
            for (int k = 0; k < E; k++) used[k] = 0;
            for (int p = 0; p < 3; p++) if (mSel[p] >= 0) used[mSel[p]] = 1;
            for (int p = 0; p < 3; p++) begin
                for (int k = 0; k < E; k++) begin
                    int idx;
                    idx = (mPtr[p] + k) % E;
                    if (rdy[p][idx] && !used[idx]) begin
                        newSel[p] = idx;
                        break;
                    end
                end
                if (newSel[p] >= 0) begin
                    used[newSel[p]] = 1;
                    mPtr[p] = (newSel[p] + 1) % E;
                    if (mCnt[p] < CMAX) mCnt[p]++;
                end
            end
        end
        for (int p = 0; p < 3; p++) mSel[p] = newSel[p];
        e.s0 = toVec(mSel[0]);
        e.s1 = toVec(mSel[1]);
        e.s2 = toVec(mSel[2]);
        e.v  = {mSel[2] >= 0, mSel[1] >= 0, mSel[0] >= 0};
        e.c0 = CW'(mCnt[0]);
        e.c1 = CW'(mCnt[1]);
        e.c2 = CW'(mCnt[2]);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [E-1:0] r0, input logic [E-1:0] r1,
                                 input logic [E-1:0] r2, input logic st,
                                 input logic thr, input logic rn);
        @(negedge clk);
        portReady0 = r0;
        portReady1 = r1;
        portReady2 = r2;
        stall      = st;
        rst_thread = thr;
        rst_n      = rn;
        modelStep(r0, r1, r2, st, thr, rn);
    endtask

    // Monitor: one expectation is due shortly after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("outRsSelect0", 32'(outRsSelect0), 32'(e.s0));
                checkOutput("outRsSelect1", 32'(outRsSelect1), 32'(e.s1));
                checkOutput("outRsSelect2", 32'(outRsSelect2), 32'(e.s2));
                checkOutput("issueValid",   32'(issueValid),   32'(e.v));
                checkOutput("issueCnt0",    32'(issueCnt0),    32'(e.c0));
                checkOutput("issueCnt1",    32'(issueCnt1),    32'(e.c1));
                checkOutput("issueCnt2",    32'(issueCnt2),    32'(e.c2));
            end
        end
    end

    initial begin
        // Reset
        repeat (2) applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Single entry held ready on port 0: grant, masked, grant
        repeat (3) applyStimulus(8'h08, '0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Ports 0 and 1 competing for entry 2, then port 1 moves on
        applyStimulus(8'h04, 8'h04, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, 8'h14, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Rotation with wrap on port 2
        repeat (18) applyStimulus('0, '0, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Stall with everything ready, then resume
        repeat (2) applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Thread flush overriding stall, then a fresh pick from entry 0
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h81, '0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Drive port 1 into saturation, then reset in the middle of traffic
        repeat (40) applyStimulus('0, 8'hFF, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional stall, flush and reset
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(E'($urandom), E'($urandom), E'($urandom),
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 255) != 0);
        end

        applyStimulus('0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
